// File: rtl/cpu_if_if.sv
// Instruction-memory read bus between the fetch stage (master) and the memory (slave).
// A request is held with a stable address until the memory answers with valid.
interface cpu_if_if;
    logic        req;
    logic [15:0] addr;
    logic [15:0] data;
    logic        valid;

    modport master (output req, output addr, input data, input valid);
    modport slave  (input req, input addr, output data, output valid);
endinterface

// File: rtl/cpu_if.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, fetches over a
// req/valid memory bus, honours stall and branch redirects, and stops after HLT.
module cpu_if #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branchTake,
    input  logic [15:0] pcBranch,
    cpu_if_if.master    imem,
    output logic [15:0] instrOut,
    output logic [15:0] pcOut,
    output logic        validOut,
    output logic        fetchBusy,
    output logic        fetchHalted
);

    typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HOLD, S_HALTED} state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] target_reg, target_next;
    logic [15:0] buf_instr_reg, buf_instr_next;
    logic [15:0] buf_pc_reg, buf_pc_next;
    logic [15:0] instr_reg, instr_next;
    logic [15:0] pcout_reg, pcout_next;
    logic        valid_reg, valid_next;

    logic        redirect;
    logic        data_halt;
    logic        buf_halt;
    logic [15:0] pc_plus2;

    assign redirect  = branchTake & ~stall;
    assign data_halt = (imem.data[15:12] == HALT_OPCODE);
    assign buf_halt  = (buf_instr_reg[15:12] == HALT_OPCODE);
    assign pc_plus2  = pc_reg + 16'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_FETCH;
            pc_reg        <= RESET_PC;
            target_reg    <= 16'h0000;
            buf_instr_reg <= 16'h0000;
            buf_pc_reg    <= 16'h0000;
            instr_reg     <= NOP_INSTR;
            pcout_reg     <= 16'h0000;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            target_reg    <= target_next;
            buf_instr_reg <= buf_instr_next;
            buf_pc_reg    <= buf_pc_next;
            instr_reg     <= instr_next;
            pcout_reg     <= pcout_next;
            valid_reg     <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                if (redirect)
                    state_next = imem.valid ? S_FETCH : S_DRAIN;
                else if (imem.valid)
                    state_next = stall ? S_HOLD : (data_halt ? S_HALTED : S_FETCH);
            end
            S_DRAIN: begin
                if (imem.valid)
                    state_next = S_FETCH;
            end
            S_HOLD: begin
                if (redirect)
                    state_next = S_FETCH;
                else if (!stall)
                    state_next = buf_halt ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                if (redirect)
                    state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Datapath next values; IF/ID holds unless explicitly written below.
    always_comb begin
        pc_next        = pc_reg;
        target_next    = target_reg;
        buf_instr_next = buf_instr_reg;
        buf_pc_next    = buf_pc_reg;
        instr_next     = instr_reg;
        pcout_next     = pcout_reg;
        valid_next     = valid_reg;
        case (state_reg)
            S_FETCH: begin
                if (redirect) begin
                    if (imem.valid)
                        pc_next = pcBranch;
                    else
                        target_next = pcBranch;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end else if (imem.valid && !stall) begin
                    instr_next = imem.data;
                    pcout_next = pc_plus2;
                    valid_next = 1'b1;
                    if (!data_halt)
                        pc_next = pc_plus2;
                end else if (imem.valid) begin
                    buf_instr_next = imem.data;
                    buf_pc_next    = pc_plus2;
                end else if (!stall) begin
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end
            end
            S_DRAIN: begin
                if (redirect)
                    target_next = pcBranch;
                if (imem.valid)
                    pc_next = redirect ? pcBranch : target_reg;
                instr_next = NOP_INSTR;
                valid_next = 1'b0;
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_next    = pcBranch;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end else if (!stall) begin
                    instr_next = buf_instr_reg;
                    pcout_next = buf_pc_reg;
                    valid_next = 1'b1;
                    if (!buf_halt)
                        pc_next = buf_pc_reg;
                end
            end
            S_HALTED: begin
                if (redirect) begin
                    pc_next    = pcBranch;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // The request is suppressed during reset so an abandoned fetch is visible to memory.
    always_comb begin
        imem.req    = ((state_reg == S_FETCH) || (state_reg == S_DRAIN)) && !rst;
        imem.addr   = pc_reg;
        fetchBusy   = ((state_reg == S_FETCH) || (state_reg == S_DRAIN)) && !imem.valid;
        fetchHalted = (state_reg == S_HALTED);
        instrOut    = instr_reg;
        pcOut       = pcout_reg;
        validOut    = valid_reg;
    end

endmodule

// File: tb/tb_cpu_if.sv
// Bench for cpu_if: a variable-latency memory model plus a program-order scoreboard
// that predicts the delivered instruction stream from redirects, resets and HLT words.
module tb_cpu_if;
    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branchTake = 1'b0;
    logic [15:0] pcBranch = 16'h0000;
    logic [15:0] instrOut, pcOut;
    logic        validOut, fetchBusy, fetchHalted;

    cpu_if_if imem();

    cpu_if dut (
        .clk(clk), .rst(rst), .stall(stall), .branchTake(branchTake), .pcBranch(pcBranch),
        .imem(imem), .instrOut(instrOut), .pcOut(pcOut), .validOut(validOut),
        .fetchBusy(fetchBusy), .fetchHalted(fetchHalted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int deliveries = 0;
    int fixed_wait = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a[6:0] == 7'h20) ? 16'hF000 : {4'h1, a[11:0]};
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Scoreboard state: next program-order address expected in IF/ID.
    logic [15:0] exp_q[$];
    logic        halted_m = 1'b0;
    logic        started = 1'b0;
    logic        prv_rst, prv_stall, prv_redir;
    logic [15:0] prv_target, prv_instr, prv_pc;
    logic        prv_valid;
    logic        mem_busy = 1'b0;
    int          mem_wait = 0;
    logic [15:0] mem_addr = 16'h0000;

    always @(negedge clk) begin
        logic [15:0] a, w;
        if (started) begin
            if (prv_rst) begin
                check1("rst_valid", validOut, 1'b0);
                check16("rst_instr", instrOut, NOP);
                check16("rst_pcout", pcOut, 16'h0000);
                check16("rst_pc", imem.addr, 16'h0000);
                exp_q.delete();
                exp_q.push_back(16'h0000);
                halted_m = 1'b0;
            end else if (prv_redir) begin
                check1("redir_valid", validOut, 1'b0);
                check16("redir_instr", instrOut, NOP);
                exp_q.delete();
                exp_q.push_back(prv_target);
                halted_m = 1'b0;
            end else if (prv_stall || halted_m) begin
                check16("hold_instr", instrOut, prv_instr);
                check16("hold_pcout", pcOut, prv_pc);
                check1("hold_valid", validOut, prv_valid);
            end else if (validOut) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_delivery actual=%h@%h required=none", instrOut, pcOut);
                end else begin
                    a = exp_q.pop_front();
                    w = mem_word(a);
                    check16("deliv_instr", instrOut, w);
                    check16("deliv_pcout", pcOut, a + 16'd2);
                    deliveries++;
                    if (w[15:12] == 4'hF)
                        halted_m = 1'b1;
                    else
                        exp_q.push_back(a + 16'd2);
                end
            end else begin
                check16("bubble_instr", instrOut, NOP);
            end
            check1("halted", fetchHalted, halted_m);
        end
        // Memory: one outstanding request, answered after a chosen number of wait cycles.
        if (imem.valid === 1'b1)
            mem_busy = 1'b0;
        if (imem.req !== 1'b1) begin
            mem_busy   = 1'b0;
            imem.valid = 1'b0;
            imem.data  = 16'($urandom);
        end else begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
                mem_addr = imem.addr;
            end else begin
                check16("addr_stable", imem.addr, mem_addr);
            end
            if (mem_wait == 0) begin
                imem.valid = 1'b1;
                imem.data  = mem_word(imem.addr);
            end else begin
                imem.valid = 1'b0;
                imem.data  = 16'($urandom);
                mem_wait--;
            end
        end
        prv_rst    = rst;
        prv_stall  = stall;
        prv_redir  = branchTake & ~stall;
        prv_target = pcBranch;
        prv_instr  = instrOut;
        prv_pc     = pcOut;
        prv_valid  = validOut;
        started    = 1'b1;
    end

    always @(negedge clk) begin
        #2;
        if (started) begin
            if (rst)
                check1("req_in_rst", imem.req, 1'b0);
            else
                check1("fetch_busy", fetchBusy, imem.req & ~imem.valid);
        end
    end

    task automatic pulse_branch(input logic [15:0] t);
        @(posedge clk); #1;
        branchTake = 1'b1;
        pcBranch   = t;
        @(posedge clk); #1;
        branchTake = 1'b0;
    endtask

    initial begin
        logic seen;
        fixed_wait = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait memory: one instruction per cycle straight after reset.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk); #1;
            check16("seq_instr", instrOut, 16'h1000 + 16'(2 * k));
            check16("seq_pcout", pcOut, 16'(2 * k + 2));
            check1("seq_valid", validOut, 1'b1);
        end

        // Run into the HLT word at 0x0020.
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk); #1;
            seen = fetchHalted;
        end
        check1("halt_reached", seen, 1'b1);
        check16("halt_instr", instrOut, 16'hF000);
        check16("halt_pcout", pcOut, 16'h0022);
        check1("halt_req", imem.req, 1'b0);

        pulse_branch(16'h0040);
        @(negedge clk);
        check16("resume_addr", imem.addr, 16'h0040);

        // PC wrap-around at the top of the address space.
        pulse_branch(16'hFFFC);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); #1;
            seen = validOut && (pcOut == 16'h0000);
        end
        check1("wrap_seen", seen, 1'b1);

        // Redirect during a slow fetch, then reset while draining.
        fixed_wait = 2;
        @(posedge clk); #1;
        pulse_branch(16'h0100);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // Randomised traffic: latency, stall, redirects, occasional reset.
        fixed_wait = -1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst        = ($urandom % 300 == 0);
            stall      = ($urandom % 4 == 0);
            branchTake = ($urandom % 12 == 0);
            pcBranch   = ($urandom % 8 == 0) ? 16'(16'hFFF0 + 2 * ($urandom % 8))
                                             : 16'(2 * ($urandom % 128));
        end
        @(posedge clk); #1;
        rst = 1'b0; stall = 1'b0; branchTake = 1'b0;
        repeat (5) @(posedge clk);

        checks++;
        if (deliveries < 300) begin
            failures++;
            $display("FAIL deliveries actual=%0d required>=300", deliveries);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_if.md
Name: cpu_IF

Overview:
- Instruction-fetch stage of the 16-bit five-stage pipeline. Sits directly upstream of cpu_ID.
- Owns the PC register and the IF/ID pipeline register. Talks to a variable-latency instruction memory through a req/valid handshake.
- Feeds cpu_ID with instr and pc+2. Consumes cpu_ID's branchTake/pcBranch redirect and the hazard unit's stall.
- Stops fetching after a HLT instruction is delivered.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, bubble encoding placed in IF/ID (ADD r0,r0,r0).
- HALT_OPCODE, 4'hF, opcode (instr[15:12]) that stops fetching.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- branchTake  in  1  from cpu_ID: redirect fetch.
- pcBranch  in  16  from cpu_ID: redirect target.
- imemReq  out  1  instruction read request.
- imemAddr  out  16  read address; stable while imemReq=1.
- imemData  in  16  read data; valid only when imemValid=1.
- imemValid  in  1  memory completes the outstanding request (same cycle as req or later).
- instrOut  out  16  IF/ID instruction.
- pcOut  out  16  IF/ID fetch address + 2.
- validOut  out  1  IF/ID holds a real instruction.
- fetchBusy  out  1  IF waiting on memory (state FETCH or DRAIN and imemValid=0).
- fetchHalted  out  1  state == HALTED.

Behaviour:
- Registers: pc, state, target, buffer (instr, pc+2), and IF/ID (instrOut, pcOut, validOut).
- Reset (rst=1 at posedge):
  - pc=RESET_PC, state=FETCH.
  - instrOut=NOP_INSTR, pcOut=0, validOut=0, buffer cleared.
  - While rst=1, imemReq=0.
- Outputs:
  - imemReq=1 exactly in FETCH and DRAIN.
  - imemAddr=pc at all times.
- Redirect = branchTake & ~stall. Priority: rst > redirect > stall > normal.
- States:
  - FETCH: req asserted.
    - Redirect with imemValid=1: discard data, pc<=pcBranch, stay FETCH.
    - Redirect with imemValid=0: target<=pcBranch, go DRAIN.
    - No redirect, imemValid=1, stall=0: IF/ID<={imemData, pc+2, 1}, pc<=pc+2. If imemData[15:12]==HALT_OPCODE, go HALTED and leave pc unchanged; else stay FETCH.
    - No redirect, imemValid=1, stall=1: buffer<={imemData, pc+2}, go HOLD. IF/ID holds.
    - imemValid=0, stall=0: IF/ID<=bubble (NOP_INSTR, pcOut unchanged, validOut=0).
    - imemValid=0, stall=1: IF/ID holds.
  - DRAIN: wrong-path request outstanding. req/addr held.
    - A further redirect overwrites target.
    - On imemValid: discard data, pc<=target (or pcBranch if redirecting that same cycle), go FETCH.
    - IF/ID holds bubble.
  - HOLD: req=0, waiting for stall to drop.
    - stall=0 and no redirect: IF/ID<=buffer with validOut=1, then apply the same halt check and pc advance as FETCH delivery.
    - Redirect: discard buffer, pc<=pcBranch, go FETCH.
  - HALTED: req=0, pc frozen at the HLT address.
    - Redirect: pc<=pcBranch, go FETCH. This covers a HLT on the wrong path.
    - Otherwise remain HALTED until rst.
- Every redirect loads IF/ID with a bubble (NOP_INSTR, validOut=0) the same edge.
- pc arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000 with no special case.
- imemValid outside FETCH/DRAIN is ignored.
- rst asserted mid-request abandons it. The memory must tolerate req dropping.
- Latency: with zero-wait memory and no stall, one instruction enters IF/ID per cycle; instruction at addr A is visible on instrOut the cycle after it is fetched.

Test Plan:
1. Zero-wait memory returning instr=addr|16'h1000, no stall, 4 cycles after reset -> instrOut 16'h1000,16'h1002,16'h1004,16'h1006 on consecutive cycles; pcOut 2,4,6,8; validOut=1.
2. Memory latency 3 cycles -> imemAddr stable for 3 cycles with req=1, fetchBusy=1, two bubbles (validOut=0) between instructions, no PC advance until imemValid.
3. stall=1 for 2 cycles while data returns at pc=16'h0010 -> state HOLD, req=0, IF/ID unchanged. After stall drops, instrOut=buffered word, pcOut=16'h0012, next imemAddr=16'h0012.
4. branchTake=1, pcBranch=16'h0100 while a 3-cycle fetch of 16'h0008 is outstanding -> req/addr held at 16'h0008 until valid, data discarded, next imemAddr=16'h0100, validOut=0 throughout.
5. Memory returns 16'hF000 at pc=16'h0020 -> delivered with validOut=1, fetchHalted=1, imemReq=0 thereafter. A later branchTake to 16'h0040 resumes fetching at 16'h0040.
6. rst pulsed during DRAIN, and pc=16'hFFFE wrap -> after reset pc=RESET_PC, validOut=0. Wrap case: next imemAddr=16'h0000, pcOut=16'h0000.
